// File: rtl/spi_ram_target_if.sv
// spi_ram_target_if: SPI pin bundle between an initiator and the RAM target.
// The master modport is the initiator side and the slave modport is the target side.
interface spi_ram_target_if;
   logic spi_clk;
   logic spi_select;
   logic spi_mosi;
   logic spi_miso;
   logic active;
   logic cmd_err;

   modport master (
      output spi_clk,
      output spi_select,
      output spi_mosi,
      input  spi_miso,
      input  active,
      input  cmd_err
   );

   modport slave (
      input  spi_clk,
      input  spi_select,
      input  spi_mosi,
      output spi_miso,
      output active,
      output cmd_err
   );
endinterface

// File: rtl/spi_ram_target.sv
// spi_ram_target: SPI mode-0 target that exposes a byte-wide RAM.
// Supported commands are 0x03 READ and 0x02 WRITE. Each is followed by a
// 16-bit address and then streams bytes, and the address wraps at MEM_BYTES.
// SPI pins are oversampled in the clk domain, so spi_clk must be slow
// enough for the synchronizers: at least 8 clk per spi_clk period.
// Optional feature macro: SPI_RAM_TARGET_RDSR_EN adds command 0x05, which
// returns the mode register value 0x40 repeatedly until deselect.
module spi_ram_target #(
   parameter int MEM_BYTES       = 64,
   parameter int SCK_SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_ram_target_if.slave spi
);

   localparam int ADDR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam int ARM_W  = $clog2(SCK_SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_LIMIT = ARM_W'(SCK_SYNC_STAGES + 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_READ   = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_IGNORE = 3'd5;
`ifdef SPI_RAM_TARGET_RDSR_EN
   localparam logic [2:0] ST_RDSR   = 3'd6;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] RDSR_VAL  = 8'h40;
`endif
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   // Synchronizer chains and previous-sample flops for edge detection
   logic [SCK_SYNC_STAGES-1:0] sclk_sync_q;
   logic [SCK_SYNC_STAGES-1:0] sel_sync_q;
   logic [SCK_SYNC_STAGES-1:0] mosi_sync_q;
   logic                       sclk_prev_q;
   logic                       sel_prev_q;
   logic [ARM_W-1:0]           arm_cnt_q;

   // Protocol state
   logic [2:0]        state_q,   state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [15:0]       shift_q,   shift_d;
   logic              is_read_q, is_read_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [7:0]        out_q,     out_d;
   logic              skip_q,    skip_d;
   logic              miso_q,    miso_d;
   logic              active_q;
   logic              cmd_err_q;

   logic [7:0]        mem_q [MEM_BYTES];

   logic              sclk_s, sel_s, mosi_s;
   logic              armed_s;
   logic              sel_fall_s, sel_rise_s, sclk_rise_s, sclk_fall_s;
   logic [15:0]       shift_in_s;
   logic [ADDR_W-1:0] addr_inc_s;
   logic              wr_en_s;
   logic              cmd_err_s;

   assign sclk_s      = sclk_sync_q[SCK_SYNC_STAGES-1];
   assign sel_s       = sel_sync_q[SCK_SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SCK_SYNC_STAGES-1];
   assign armed_s     = (arm_cnt_q == ARM_LIMIT);
   assign sel_fall_s  = sel_prev_q & ~sel_s;
   assign sel_rise_s  = ~sel_prev_q & sel_s;
   // spi_clk edges are only meaningful while the target is selected
   assign sclk_rise_s = ~sclk_prev_q & sclk_s & ~sel_s;
   assign sclk_fall_s = sclk_prev_q & ~sclk_s & ~sel_s;
   assign shift_in_s  = {shift_q[14:0], mosi_s};
   assign addr_inc_s  = addr_q + ADDR_W'(1);

   assign spi.spi_miso = miso_q;
   assign spi.active   = active_q;
   assign spi.cmd_err  = cmd_err_q;

   // Input synchronizers, edge history, and arming after reset. The target
   // is armed only once select has been seen high for longer than the
   // synchronizer depth, so a select held low through reset is not taken
   // as the start of a command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= {SCK_SYNC_STAGES{1'b0}};
         sel_sync_q  <= {SCK_SYNC_STAGES{1'b1}};
         mosi_sync_q <= {SCK_SYNC_STAGES{1'b0}};
         sclk_prev_q <= 1'b0;
         sel_prev_q  <= 1'b1;
         arm_cnt_q   <= {ARM_W{1'b0}};
      end else begin
         sclk_sync_q[0] <= spi.spi_clk;
         sel_sync_q[0]  <= spi.spi_select;
         mosi_sync_q[0] <= spi.spi_mosi;
         for (int i = 1; i < SCK_SYNC_STAGES; i++) begin
            sclk_sync_q[i] <= sclk_sync_q[i-1];
            sel_sync_q[i]  <= sel_sync_q[i-1];
            mosi_sync_q[i] <= mosi_sync_q[i-1];
         end
         sclk_prev_q <= sclk_s;
         sel_prev_q  <= sel_s;
         if (armed_s) begin
            arm_cnt_q <= arm_cnt_q;
         end else if (sel_s) begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
         end else begin
            arm_cnt_q <= {ARM_W{1'b0}};
         end
      end
   end

   // Next-state logic: a select rising edge aborts everything and takes
   // priority over any simultaneous spi_clk edge.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      out_d     = out_q;
      skip_d    = skip_q;
      wr_en_s   = 1'b0;
      cmd_err_s = 1'b0;
      if ((state_q != ST_IDLE) && sel_rise_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_fall_s && armed_s) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = 5'd0;
                  shift_d   = 16'h0000;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CMD: begin
               if (sclk_rise_s) begin
                  shift_d = shift_in_s;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     case (shift_in_s[7:0])
                        CMD_READ: begin
                           state_d   = ST_ADDR;
                           is_read_d = 1'b1;
                        end
                        CMD_WRITE: begin
                           state_d   = ST_ADDR;
                           is_read_d = 1'b0;
                        end
`ifdef SPI_RAM_TARGET_RDSR_EN
                        CMD_RDSR: begin
                           state_d = ST_RDSR;
                           out_d   = RDSR_VAL;
                           skip_d  = 1'b1;
                        end
`endif
                        default: begin
                           state_d   = ST_IGNORE;
                           cmd_err_s = 1'b1;
                        end
                     endcase
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end else begin
                  state_d = ST_CMD;
               end
            end
            ST_ADDR: begin
               if (sclk_rise_s) begin
                  shift_d = shift_in_s;
                  if (bit_cnt_q == 5'd15) begin
                     bit_cnt_d = 5'd0;
                     addr_d    = shift_in_s[ADDR_W-1:0];
                     if (is_read_q) begin
                        state_d = ST_READ;
                        out_d   = mem_q[shift_in_s[ADDR_W-1:0]];
                        skip_d  = 1'b1;
                     end else begin
                        state_d = ST_WRITE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end else begin
                  state_d = ST_ADDR;
               end
            end
            ST_READ: begin
               // The falling edge that closes the last address bit must not
               // shift: the MSB is still owed to the next rising edge.
               if (sclk_fall_s) begin
                  if (skip_q) begin
                     skip_d = 1'b0;
                  end else if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     addr_d    = addr_inc_s;
                     out_d     = mem_q[addr_inc_s];
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                     out_d     = {out_q[6:0], 1'b0};
                  end
               end else begin
                  state_d = ST_READ;
               end
            end
`ifdef SPI_RAM_TARGET_RDSR_EN
            ST_RDSR: begin
               if (sclk_fall_s) begin
                  if (skip_q) begin
                     skip_d = 1'b0;
                  end else if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     out_d     = RDSR_VAL;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                     out_d     = {out_q[6:0], 1'b0};
                  end
               end else begin
                  state_d = ST_RDSR;
               end
            end
`endif
            ST_WRITE: begin
               if (sclk_rise_s) begin
                  shift_d = shift_in_s;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     wr_en_s   = 1'b1;
                     addr_d    = addr_inc_s;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end else begin
                  state_d = ST_WRITE;
               end
            end
            ST_IGNORE: begin
               state_d = ST_IGNORE;
            end
            default: begin
               state_d   = ST_IDLE;
               bit_cnt_d = 5'd0;
            end
         endcase
      end
   end

   // MISO follows the output shifter only while a read-type state is next
   always_comb begin
      miso_d = 1'b0;
      if (state_d == ST_READ) begin
         miso_d = out_d[7];
`ifdef SPI_RAM_TARGET_RDSR_EN
      end else if (state_d == ST_RDSR) begin
         miso_d = out_d[7];
`endif
      end else begin
         miso_d = 1'b0;
      end
   end

   // Protocol state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 5'd0;
         shift_q   <= 16'h0000;
         is_read_q <= 1'b0;
         addr_q    <= {ADDR_W{1'b0}};
         out_q     <= 8'h00;
         skip_q    <= 1'b0;
         miso_q    <= 1'b0;
         active_q  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         is_read_q <= is_read_d;
         addr_q    <= addr_d;
         out_q     <= out_d;
         skip_q    <= skip_d;
         miso_q    <= miso_d;
         active_q  <= (state_d != ST_IDLE);
         cmd_err_q <= cmd_err_s;
      end
   end

   // Backing store: never reset, so committed bytes survive a reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[addr_q] <= shift_in_s[7:0];
      end
   end

endmodule

// File: tb/tb_spi_ram_target.sv
// tb_spi_ram_target: drives SPI transactions through the interface and
// compares MISO data, cmd_err and active against a byte-array model.
module tb_spi_ram_target;

   localparam int MEM  = 64;
   localparam int HALF = 6;

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] addr;
      int          nbytes;
      int          last_bits;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [7:0]  e0;
      logic [7:0]  e1;
      logic        exp_err;
      logic        chk_rd;
   } vec_t;

   logic clk;
   logic rst_n;
   spi_ram_target_if spi_bus ();

   spi_ram_target #(.MEM_BYTES(MEM), .SCK_SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .spi   (spi_bus)
   );

   int vectors    = 0;
   int miscompares = 0;
   int err_cycles  = 0;
   int miso_hi_cnt = 0;
   int active_cnt  = 0;

   logic [7:0] wbuf [8];
   logic [7:0] rbuf [8];
   logic [7:0] model_mem [MEM];
   bit         model_val [MEM];

   always #5 clk = ~clk;

   // Observe outputs on the falling clk edge, away from the active edge
   always @(negedge clk) begin
      if (spi_bus.cmd_err)  err_cycles++;
      if (spi_bus.spi_miso) miso_hi_cnt++;
      if (spi_bus.active)   active_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [31:0] val, input int n, output logic [31:0] rx);
      rx = 32'h0;
      for (int j = n - 1; j >= 0; j--) begin
         spi_bus.spi_mosi = val[j];
         wait_clks(HALF);
         rx[j] = spi_bus.spi_miso;
         spi_bus.spi_clk = 1'b1;
         wait_clks(HALF);
         spi_bus.spi_clk = 1'b0;
      end
   endtask

   task automatic spi_op(input logic [7:0] cmd, input logic [15:0] addr, input bit has_addr,
                         input int nbytes, input int last_bits);
      logic [31:0] r;
      int          nb;
      err_cycles  = 0;
      miso_hi_cnt = 0;
      active_cnt  = 0;
      spi_bus.spi_select = 1'b0;
      wait_clks(4);
      send_bits({24'h0, cmd}, 8, r);
      if (has_addr) send_bits({16'h0, addr}, 16, r);
      for (int k = 0; k < nbytes; k++) begin
         nb = (k == nbytes - 1) ? last_bits : 8;
         send_bits({24'h0, wbuf[k]} >> (8 - nb), nb, r);
         rbuf[k] = r[7:0];
      end
      wait_clks(HALF);
      spi_bus.spi_select = 1'b1;
      spi_bus.spi_mosi   = 1'b0;
      wait_clks(12);
   endtask

   task automatic model_write(input logic [15:0] addr, input int nbytes, input int last_bits);
      int a;
      for (int k = 0; k < nbytes; k++) begin
         if ((k < nbytes - 1) || (last_bits == 8)) begin
            a = (int'(addr) + k) % MEM;
            model_mem[a] = wbuf[k];
            model_val[a] = 1'b1;
         end
      end
   endtask

   function automatic vec_t mk(input logic [7:0] cmd, input logic [15:0] addr, input int nbytes,
                               input int last_bits, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic exp_err, input logic chk_rd);
      vec_t v;
      v.cmd = cmd; v.addr = addr; v.nbytes = nbytes; v.last_bits = last_bits;
      v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.exp_err = exp_err; v.chk_rd = chk_rd;
      return v;
   endfunction

   initial begin
      vec_t        tbl [13];
      logic [31:0] r;
      logic [7:0]  cmd;
      logic [15:0] addr;
      int          n;
      int          sel;
      int          a;

      tbl[0]  = mk(8'h02, 16'h0010, 2, 8, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
      tbl[1]  = mk(8'h03, 16'h0010, 2, 8, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0, 1'b1);
      tbl[2]  = mk(8'h02, 16'h003F, 2, 8, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0);
      tbl[3]  = mk(8'h03, 16'h0000, 1, 8, 8'h00, 8'h00, 8'h22, 8'h00, 1'b0, 1'b1);
      tbl[4]  = mk(8'h03, 16'h003F, 1, 8, 8'h00, 8'h00, 8'h11, 8'h00, 1'b0, 1'b1);
      tbl[5]  = mk(8'h03, 16'h003F, 2, 8, 8'h00, 8'h00, 8'h11, 8'h22, 1'b0, 1'b1);
      tbl[6]  = mk(8'h9F, 16'h0000, 1, 8, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      tbl[7]  = mk(8'h03, 16'h0010, 2, 8, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0, 1'b1);
      tbl[8]  = mk(8'h02, 16'h0005, 1, 8, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      tbl[9]  = mk(8'h02, 16'h0005, 1, 5, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      tbl[10] = mk(8'h03, 16'h0005, 1, 8, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b1);
      tbl[11] = mk(8'h02, 16'h1045, 1, 8, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      tbl[12] = mk(8'h03, 16'h0005, 1, 8, 8'h00, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b1);

      for (int i = 0; i < MEM; i++) model_val[i] = 1'b0;
      clk = 1'b0;
      rst_n = 1'b0;
      spi_bus.spi_clk    = 1'b0;
      spi_bus.spi_select = 1'b1;
      spi_bus.spi_mosi   = 1'b0;
      wait_clks(3);
      check("reset miso", {31'h0, spi_bus.spi_miso}, 32'h0);
      check("reset active", {31'h0, spi_bus.active}, 32'h0);
      check("reset cmd_err", {31'h0, spi_bus.cmd_err}, 32'h0);
      rst_n = 1'b1;
      wait_clks(10);

      // Directed table
      for (int i = 0; i < 13; i++) begin
         wbuf[0] = tbl[i].d0;
         wbuf[1] = tbl[i].d1;
         spi_op(tbl[i].cmd, tbl[i].addr, (tbl[i].cmd == 8'h02) || (tbl[i].cmd == 8'h03),
                tbl[i].nbytes, tbl[i].last_bits);
         check($sformatf("v%0d cmd_err cycles", i), err_cycles, {31'h0, tbl[i].exp_err});
         check($sformatf("v%0d active seen", i), {31'h0, active_cnt > 0}, 32'h1);
         if (tbl[i].chk_rd) begin
            check($sformatf("v%0d rd byte0", i), {24'h0, rbuf[0]}, {24'h0, tbl[i].e0});
            if (tbl[i].nbytes > 1)
               check($sformatf("v%0d rd byte1", i), {24'h0, rbuf[1]}, {24'h0, tbl[i].e1});
         end
         if (tbl[i].exp_err)
            check($sformatf("v%0d miso high cycles", i), miso_hi_cnt, 32'h0);
         if (tbl[i].cmd == 8'h02) model_write(tbl[i].addr, tbl[i].nbytes, tbl[i].last_bits);
      end

      // Mode register read, present only with the optional command compiled in
      wbuf[0] = 8'h00;
      wbuf[1] = 8'h00;
      spi_op(8'h05, 16'h0000, 1'b0, 2, 8);
`ifdef SPI_RAM_TARGET_RDSR_EN
      check("rdsr byte0", {24'h0, rbuf[0]}, 32'h40);
      check("rdsr byte1", {24'h0, rbuf[1]}, 32'h40);
      check("rdsr cmd_err", err_cycles, 32'h0);
`else
      check("rdsr cmd_err", err_cycles, 32'h1);
      check("rdsr miso high cycles", miso_hi_cnt, 32'h0);
`endif

      // Reset in the middle of a read: outputs drop at once
      spi_bus.spi_select = 1'b0;
      wait_clks(4);
      send_bits(32'h03, 8, r);
      send_bits(32'h0010, 16, r);
      send_bits(32'h0, 2, r);
      check("midread first bits", {30'h0, r[1:0]}, 32'h2);
      wait_clks(4);
      check("midread miso before rst", {31'h0, spi_bus.spi_miso}, 32'h1);
      check("midread active before rst", {31'h0, spi_bus.active}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("midread miso in rst", {31'h0, spi_bus.spi_miso}, 32'h0);
      check("midread active in rst", {31'h0, spi_bus.active}, 32'h0);
      wait_clks(3);
      rst_n = 1'b1;
      spi_bus.spi_select = 1'b1;
      wait_clks(12);
      wbuf[0] = 8'h00;
      wbuf[1] = 8'h00;
      spi_op(8'h03, 16'h0010, 1'b1, 2, 8);
      check("postrst rd byte0", {24'h0, rbuf[0]}, {24'h0, model_mem[16]});
      check("postrst rd byte1", {24'h0, rbuf[1]}, {24'h0, model_mem[17]});

      // Reset released with select already low: that transaction is ignored
      spi_bus.spi_select = 1'b0;
      rst_n = 1'b0;
      wait_clks(2);
      rst_n = 1'b1;
      wait_clks(10);
      wbuf[0] = 8'h77;
      spi_op(8'h02, 16'h0010, 1'b1, 1, 8);
      check("held select active", {31'h0, active_cnt > 0}, 32'h0);
      wbuf[0] = 8'h00;
      spi_op(8'h03, 16'h0010, 1'b1, 1, 8);
      check("held select rd", {24'h0, rbuf[0]}, {24'h0, model_mem[16]});

      // Randomized traffic against the model
      for (int i = 0; i < 30; i++) begin
         sel  = $urandom_range(0, 9);
         addr = 16'($urandom);
         n    = $urandom_range(1, 4);
         if (sel < 4) begin
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            spi_op(8'h02, addr, 1'b1, n, 8);
            model_write(addr, n, 8);
            check($sformatf("rnd%0d wr cmd_err", i), err_cycles, 32'h0);
         end else if (sel < 9) begin
            for (int k = 0; k < n; k++) wbuf[k] = 8'h00;
            spi_op(8'h03, addr, 1'b1, n, 8);
            for (int k = 0; k < n; k++) begin
               a = (int'(addr) + k) % MEM;
               if (model_val[a])
                  check($sformatf("rnd%0d rd @%0h", i, a), {24'h0, rbuf[k]}, {24'h0, model_mem[a]});
            end
         end else begin
            cmd = 8'($urandom);
            for (int t = 0; t < 8; t++) begin
               if ((cmd == 8'h02) || (cmd == 8'h03) || (cmd == 8'h05)) cmd = cmd + 8'h10;
            end
            wbuf[0] = 8'h00;
            spi_op(cmd, 16'h0000, 1'b0, 1, 8);
            check($sformatf("rnd%0d bad cmd %0h cmd_err", i, cmd), err_cycles, 32'h1);
            check($sformatf("rnd%0d bad cmd miso", i), miso_hi_cnt, 32'h0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
